alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, depth of the outstanding-transaction tag FIFO (power of two, 2..16).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pushin0, pushin1  input  1 each  requester i presents an operation.
REQ-005 a0, b0, a1, b1  input  8 each  operands of requester i.
REQ-006 ci0, ci1  input  1 each  carry-in of requester i.
REQ-007 ctl0, ctl1  input  2 each  ALU op select of requester i.
REQ-008 stopout0, stopout1  output  1 each  requester i operation not accepted this cycle.
REQ-009 alu_pushin  output  1; alu_a, alu_b  output  8; alu_ci  output  1; alu_ctl  output  2  forwarded operation to ALU.
REQ-010 alu_stopout  input  1  ALU cannot accept an operation.
REQ-011 alu_pushout  input  1; alu_z  input  8; alu_cout  input  1  ALU result.
REQ-012 alu_stopin  output  1  backpressure to ALU result port.
REQ-013 pushout0, pushout1  output  1; z0, z1  output  8; cout0, cout1  output  1  result returned to requester i.
REQ-014 stopin0, stopin1  input  1 each  requester i cannot accept a result.
REQ-015 outstanding  output  $clog2(DEPTH)+1  count of tags in FIFO.
REQ-016 err  output  1  sticky protocol error flag.

Function
REQ-017 Transfer on any push/stop port occurs at a posedge where push=1 and stop=0; both sides hold data stable while push=1 and stop=1.
REQ-018 Eligible requester i: pushin_i=1; operation issue permitted when alu_stopout=0 and outstanding<DEPTH.
REQ-019 Round-robin: register last (1 bit); if both eligible, grant requester !last; if one eligible, grant it; grant combinational from current inputs.
REQ-020 Issue permitted and grant g: alu_pushin=1, alu_a/b/ci/ctl = a_g/b_g/ci_g/ctl_g, stopout_g=0, other stopout=1.
REQ-021 No grant: alu_pushin=0, stopout0=stopout1=1, alu_a/b/ci/ctl driven to 0.
REQ-022 Accepted issue (alu_pushin & !alu_stopout): tag g written at FIFO tail, last<=g.
REQ-023 Full (outstanding==DEPTH): no issue, even if a response pop occurs the same cycle.
REQ-024 Response routing: head tag h selects destination; pushout_h=alu_pushout, z_h=alu_z, cout_h=alu_cout; other pushout=0, its z/cout=0.
REQ-025 alu_stopin = stopin_h when FIFO non-empty; alu_stopin=1 when FIFO empty.
REQ-026 Accepted response (alu_pushout & !alu_stopin, FIFO non-empty): head popped.
REQ-027 Simultaneous accepted issue and accepted response (not full): push and pop both performed, outstanding unchanged.
REQ-028 alu_pushout=1 with FIFO empty: err<=1 (sticky until reset), no pop, no pushout asserted.
REQ-029 FIFO pointers wrap modulo DEPTH; outstanding never exceeds DEPTH nor underflows.
REQ-030 Results delivered to each requester in its issue order; ALU assumed in-order.

Reset
REQ-031 rst=1 asynchronously: FIFO pointers and outstanding=0, last=1 (requester 0 wins first tie), err=0.
REQ-032 During and after reset, before any input change: alu_pushin=0, stopout0=stopout1=1, pushout0=pushout1=0, alu_stopin=1.
REQ-033 Reset mid-operation discards all outstanding tags; later ALU results set err.

Verification
REQ-034 Both pushin=1 continuously, alu_stopout=0, ALU returns results next cycle, stopins=0 -> grants alternate 0,1,0,1; results z0/z1 match each requester's op.
REQ-035 a0=8'hF0,b0=8'h20,ci0=1,ctl0=0 single request -> alu_a=F0,alu_b=20,alu_ci=1 same cycle; returned z/cout appear only on port 0.
REQ-036 DEPTH=4, ALU never returns, pushin0=1 -> 4 transfers, outstanding=4, stopout0=1 thereafter.
REQ-037 Head tag=1, stopin1=1, alu_pushout=1 -> alu_stopin=1, no pop; release stopin1 -> pushout1=1 one transfer, outstanding decrements.
REQ-038 alu_pushout=1 with outstanding=0 -> err=1 next cycle and stays 1 until rst.
REQ-039 Full FIFO with simultaneous response pop and pushin0=1 -> no issue that cycle, outstanding=3, issue next cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
//   - Round-robin issue of requester operations (pushin/stopout handshake)
//     onto the ALU operation port (alu_pushin/alu_stopout).
//   - A tag FIFO of depth DEPTH records which requester owns each
//     in-flight operation; ALU results (alu_pushout/alu_stopin) are
//     steered back to the requester named by the head tag.
// Ports:
//   clk, rst                      clock, async active-high reset
//   pushin*/a*/b*/ci*/ctl*        requester operations in
//   stopout*                      requester backpressure out
//   alu_pushin/a/b/ci/ctl         operation to ALU
//   alu_stopout                   ALU backpressure in
//   alu_pushout/z/cout            ALU result in
//   alu_stopin                    backpressure to ALU result port
//   pushout*/z*/cout*             results to requesters
//   stopin*                       requester result backpressure in
//   outstanding                   tags currently held in the FIFO
//   err                           sticky: ALU result with no tag pending
module alu_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pushin0,
  input  logic                   pushin1,
  input  logic [7:0]             a0,
  input  logic [7:0]             b0,
  input  logic [7:0]             a1,
  input  logic [7:0]             b1,
  input  logic                   ci0,
  input  logic                   ci1,
  input  logic [1:0]             ctl0,
  input  logic [1:0]             ctl1,
  output logic                   stopout0,
  output logic                   stopout1,
  output logic                   alu_pushin,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic                   alu_ci,
  output logic [1:0]             alu_ctl,
  input  logic                   alu_stopout,
  input  logic                   alu_pushout,
  input  logic [7:0]             alu_z,
  input  logic                   alu_cout,
  output logic                   alu_stopin,
  output logic                   pushout0,
  output logic                   pushout1,
  output logic [7:0]             z0,
  output logic [7:0]             z1,
  output logic                   cout0,
  output logic                   cout1,
  input  logic                   stopin0,
  input  logic                   stopin1,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] r_tags;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_last;
  logic             r_err;

  logic w_full;
  logic w_empty;
  logic w_issue_ok;
  logic w_gnt_vld;
  logic w_gnt;
  logic w_head;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  // Full blocks issue even when a pop happens in the same cycle.
  assign w_issue_ok = !alu_stopout && !w_full;
  assign w_head     = r_tags[r_rptr];

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (w_issue_ok) begin
      if (pushin0 && pushin1) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ~r_last;
      end else if (pushin0) begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b0;
      end else if (pushin1) begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b1;
      end
    end
  end

  always_comb begin
    alu_pushin = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ci     = 1'b0;
    alu_ctl    = '0;
    stopout0   = 1'b1;
    stopout1   = 1'b1;
    if (w_gnt_vld) begin
      alu_pushin = 1'b1;
      if (w_gnt) begin
        alu_a    = a1;
        alu_b    = b1;
        alu_ci   = ci1;
        alu_ctl  = ctl1;
        stopout1 = 1'b0;
      end else begin
        alu_a    = a0;
        alu_b    = b0;
        alu_ci   = ci0;
        alu_ctl  = ctl0;
        stopout0 = 1'b0;
      end
    end
  end

  // Result routing: nothing is forwarded while the FIFO is empty, so a
  // stray ALU result only raises err.
  always_comb begin
    pushout0   = 1'b0;
    pushout1   = 1'b0;
    z0         = '0;
    z1         = '0;
    cout0      = 1'b0;
    cout1      = 1'b0;
    alu_stopin = 1'b1;
    if (!w_empty) begin
      if (w_head) begin
        pushout1   = alu_pushout;
        z1         = alu_z;
        cout1      = alu_cout;
        alu_stopin = stopin1;
      end else begin
        pushout0   = alu_pushout;
        z0         = alu_z;
        cout0      = alu_cout;
        alu_stopin = stopin0;
      end
    end
  end

  assign w_push = alu_pushin && !alu_stopout;
  assign w_pop  = alu_pushout && !alu_stopin && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tags  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_wptr] <= w_gnt;
        r_wptr         <= r_wptr + 1'b1;
        r_last         <= w_gnt;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (alu_pushout && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding = r_count;
  assign err         = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (DEPTH=4). The bench plays
// both requesters and the ALU; expected values are hand-computed constants.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       pushin0, pushin1;
  logic [7:0] a0, b0, a1, b1;
  logic       ci0, ci1;
  logic [1:0] ctl0, ctl1;
  logic       stopout0, stopout1;
  logic       alu_pushin;
  logic [7:0] alu_a, alu_b;
  logic       alu_ci;
  logic [1:0] alu_ctl;
  logic       alu_stopout;
  logic       alu_pushout;
  logic [7:0] alu_z;
  logic       alu_cout;
  logic       alu_stopin;
  logic       pushout0, pushout1;
  logic [7:0] z0, z1;
  logic       cout0, cout1;
  logic       stopin0, stopin1;
  logic [2:0] outstanding;
  logic       err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_arbiter #(.DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .pushin0(pushin0), .pushin1(pushin1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ci0(ci0), .ci1(ci1), .ctl0(ctl0), .ctl1(ctl1),
    .stopout0(stopout0), .stopout1(stopout1),
    .alu_pushin(alu_pushin), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ci(alu_ci), .alu_ctl(alu_ctl), .alu_stopout(alu_stopout),
    .alu_pushout(alu_pushout), .alu_z(alu_z), .alu_cout(alu_cout),
    .alu_stopin(alu_stopin),
    .pushout0(pushout0), .pushout1(pushout1), .z0(z0), .z1(z1),
    .cout0(cout0), .cout1(cout1), .stopin0(stopin0), .stopin1(stopin1),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       g, pg;
  logic [7:0] exp_z;

  initial begin
    rst = 1'b1;
    pushin0 = 0; pushin1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    ci0 = 0; ci1 = 0; ctl0 = 0; ctl1 = 0;
    alu_stopout = 0; alu_pushout = 0; alu_z = 0; alu_cout = 0;
    stopin0 = 0; stopin1 = 0;
    tick(); tick();
    #1;
    chk("rst_alu_pushin", 32'(alu_pushin), 0);
    chk("rst_stopout0", 32'(stopout0), 1);
    chk("rst_stopout1", 32'(stopout1), 1);
    chk("rst_pushouts", 32'({pushout0, pushout1}), 0);
    chk("rst_alu_stopin", 32'(alu_stopin), 1);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    tick();

    // Single request from requester 0, forwarded combinationally.
    pushin0 = 1; a0 = 8'hF0; b0 = 8'h20; ci0 = 1; ctl0 = 2'd0;
    #1;
    chk("fwd_alu_pushin", 32'(alu_pushin), 1);
    chk("fwd_alu_a", 32'(alu_a), 32'hF0);
    chk("fwd_alu_b", 32'(alu_b), 32'h20);
    chk("fwd_alu_ci", 32'(alu_ci), 1);
    chk("fwd_alu_ctl", 32'(alu_ctl), 0);
    chk("fwd_stopouts", 32'({stopout0, stopout1}), 32'b01);
    tick();
    pushin0 = 0;
    #1;
    chk("fwd_idle_alu_a", 32'(alu_a), 0);
    chk("fwd_outstanding", 32'(outstanding), 1);
    chk("fwd_alu_stopin", 32'(alu_stopin), 0);
    alu_pushout = 1; alu_z = 8'h11; alu_cout = 1;
    #1;
    chk("ret0_pushout0", 32'(pushout0), 1);
    chk("ret0_z0", 32'(z0), 32'h11);
    chk("ret0_cout0", 32'(cout0), 1);
    chk("ret0_port1", 32'({pushout1, z1, cout1}), 0);
    tick();
    alu_pushout = 0; alu_z = 0; alu_cout = 0;
    #1;
    chk("ret0_outstanding", 32'(outstanding), 0);

    // Async reset restores last=1 so requester 0 wins the first tie.
    rst = 1; #1;
    chk("arst_outstanding", 32'(outstanding), 0);
    tick();
    rst = 0;

    // Both requesting continuously; ALU answers one cycle later.
    pushin0 = 1; a0 = 8'h01; b0 = 8'h02;
    pushin1 = 1; a1 = 8'h10; b1 = 8'h20;
    pg = 0;
    for (int k = 0; k < 5; k++) begin
      g = k[0];
      if (k == 4) begin
        pushin0 = 0; pushin1 = 0;
      end
      if (k >= 1) begin
        exp_z = pg ? 8'h30 : 8'h03;
        alu_pushout = 1; alu_z = exp_z;
      end
      #1;
      if (k < 4) begin
        chk("rr_alu_a", 32'(alu_a), g ? 32'h10 : 32'h01);
        chk("rr_stopout0", 32'(stopout0), 32'(g));
        chk("rr_stopout1", 32'(stopout1), 32'(!g));
      end
      if (k >= 1) begin
        chk("rr_pushout", 32'({pushout1, pushout0}), pg ? 32'b10 : 32'b01);
        chk("rr_z", 32'(pg ? z1 : z0), 32'(exp_z));
      end
      tick();
      alu_pushout = 0;
      #1;
      chk("rr_outstanding", 32'(outstanding), (k < 4) ? 1 : 0);
      pg = g;
    end

    // Head tag 1 with requester 1 stalled: ALU result must wait.
    pushin1 = 1;
    tick();
    pushin1 = 0; stopin1 = 1; alu_pushout = 1; alu_z = 8'h55;
    #1;
    chk("stall_alu_stopin", 32'(alu_stopin), 1);
    chk("stall_pushout", 32'({pushout1, pushout0}), 32'b10);
    tick();
    chk("stall_outstanding", 32'(outstanding), 1);
    stopin1 = 0;
    #1;
    chk("rel_alu_stopin", 32'(alu_stopin), 0);
    chk("rel_z1", 32'(z1), 32'h55);
    tick();
    alu_pushout = 0;
    #1;
    chk("rel_outstanding", 32'(outstanding), 0);

    // ALU backpressure blocks issue.
    pushin0 = 1; alu_stopout = 1;
    #1;
    chk("bp_alu_pushin", 32'(alu_pushin), 0);
    chk("bp_stopout0", 32'(stopout0), 1);
    tick();
    chk("bp_outstanding", 32'(outstanding), 0);
    alu_stopout = 0;

    // Fill the FIFO with the ALU never answering.
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fill_stopout0", 32'(stopout0), (k >= 4) ? 1 : 0);
      tick();
    end
    chk("fill_outstanding", 32'(outstanding), 4);

    // Full with a pop in the same cycle: no issue until the next cycle.
    alu_pushout = 1; alu_z = 8'h77;
    #1;
    chk("fullpop_alu_pushin", 32'(alu_pushin), 0);
    chk("fullpop_pushout0", 32'(pushout0), 1);
    tick();
    alu_pushout = 0;
    #1;
    chk("fullpop_outstanding", 32'(outstanding), 3);
    chk("fullpop_reissue", 32'(stopout0), 0);
    tick();
    pushin0 = 0;
    chk("refill_outstanding", 32'(outstanding), 4);

    // Reset mid-operation discards tags; later result flags err.
    rst = 1; #1;
    chk("midrst_outstanding", 32'(outstanding), 0);
    tick();
    rst = 0;
    alu_pushout = 1; alu_z = 8'h99;
    #1;
    chk("stray_pushouts", 32'({pushout0, pushout1}), 0);
    chk("stray_alu_stopin", 32'(alu_stopin), 1);
    chk("stray_err_before", 32'(err), 0);
    tick();
    alu_pushout = 0;
    chk("stray_err", 32'(err), 1);
    tick(); tick();
    chk("stray_err_sticky", 32'(err), 1);
    chk("stray_outstanding", 32'(outstanding), 0);
    rst = 1; #1;
    chk("err_cleared", 32'(err), 0);
    tick();
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
